// File: rtl/paint_scheduler.sv
// -----------------------------------------------------------------------------
// paint_scheduler
// Sequencer and arbiter in front of the 64x24 box painter. Three requesters
// (piece erase/draw, board row redraw, HUD/score) post cell-paint commands.
// Accepted commands go through a small FIFO and are issued to the painter one
// box at a time, using a start/done handshake. A built-in sweep paints every
// board cell with a single colour after reset and whenever clear_req pulses.
//
// Ports
//   CLOCK_50     in   system clock
//   reset        in   synchronous active-high reset
//   clear_req    in   1-cycle pulse: flush FIFO, (re)start clear sweep
//   clear_color  in   3:3:3 sweep colour, latched when a sweep starts
//   req_valid    in   per-requester valid, bit 0 highest priority
//   req_ready    out  per-requester accept (combinational)
//   req_x/y/color in  packed cell x (4b), cell y (5b), colour (9b) per requester
//   paint_start  out  1-cycle start pulse to the painter
//   paint_x0/y0  out  pixel origin of the box (cell * 64, cell * 24)
//   paint_color  out  box colour
//   paint_busy   in   painter working
//   paint_done   in   painter finished, 1-cycle pulse
//   clearing     out  sweep in progress
//   sched_busy   out  FIFO non-empty or FSM not idle
//   range_err    out  sticky: an out-of-range command was seen
//
// State table
//   S_IDLE       | waiting for a queued command and an idle painter
//   S_ISSUE_WAIT | command box started, waiting for paint_done
//   S_CLR_ISSUE  | sweep: waiting for an idle painter to start the cursor cell
//   S_CLR_WAIT   | sweep: box started (or stale box draining), waiting for done
// -----------------------------------------------------------------------------
module paint_scheduler #(
  parameter int FIFO_DEPTH     = 4,
  parameter bit CLEAR_ON_RESET = 1'b1,
  parameter int COLS           = 10,
  parameter int ROWS           = 20
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        clear_req,
  input  logic [8:0]  clear_color,
  input  logic [2:0]  req_valid,
  output logic [2:0]  req_ready,
  input  logic [11:0] req_x,
  input  logic [14:0] req_y,
  input  logic [26:0] req_color,
  output logic        paint_start,
  output logic [9:0]  paint_x0,
  output logic [8:0]  paint_y0,
  output logic [8:0]  paint_color,
  input  logic        paint_busy,
  input  logic        paint_done,
  output logic        clearing,
  output logic        sched_busy,
  output logic        range_err
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LX = COLS - 1;
  localparam int LY = ROWS - 1;
  localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];
  localparam logic [4:0]  COLS_L  = COLS[4:0];
  localparam logic [5:0]  ROWS_L  = ROWS[5:0];
  localparam logic [3:0]  LAST_X  = LX[3:0];
  localparam logic [4:0]  LAST_Y  = LY[4:0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE_WAIT,
    S_CLR_ISSUE,
    S_CLR_WAIT
  } state_t;

  state_t r_state, w_state_nxt;

  // FIFO storage: {x[3:0], y[4:0], colour[8:0]}
  logic [17:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic          w_full, w_empty, w_wr, w_pop;

  logic [1:0]    w_sel;
  logic          w_acc, w_in_range;
  logic [3:0]    w_sel_x;
  logic [4:0]    w_sel_y;
  logic [8:0]    w_sel_c;
  logic [3:0]    w_head_x;
  logic [4:0]    w_head_y;
  logic [8:0]    w_head_c;

  logic [3:0]    r_cx;
  logic [4:0]    r_cy;
  logic [8:0]    r_clr_color;
  logic          r_clearing, r_skip_adv, r_range_err;

  logic          r_start;
  logic [9:0]    r_x0;
  logic [8:0]    r_y0;
  logic [8:0]    r_color;

  logic          w_issue_cmd, w_issue_clr, w_adv, w_skip_done;
  logic          w_outstanding, w_last;

  function automatic logic [9:0] f_x_pix(input logic [3:0] x);
    return {x, 6'b0};
  endfunction

  // y*24 as y*16 + y*8; 19*24 = 456 fits in 9 bits
  function automatic logic [8:0] f_y_pix(input logic [4:0] y);
    return {y, 4'b0} + {1'b0, y, 3'b0};
  endfunction

  assign w_full  = (r_count == DEPTH_L);
  assign w_empty = (r_count == '0);

  // ---------------------------------------------------------------------------
  // Fixed-priority arbiter; nothing is granted while a sweep runs or starts
  // ---------------------------------------------------------------------------
  always_comb begin
    req_ready = 3'b000;
    w_sel     = 2'd0;
    if (!w_full && !r_clearing && !clear_req) begin
      if (req_valid[0]) begin
        req_ready = 3'b001;
        w_sel     = 2'd0;
      end else if (req_valid[1]) begin
        req_ready = 3'b010;
        w_sel     = 2'd1;
      end else if (req_valid[2]) begin
        req_ready = 3'b100;
        w_sel     = 2'd2;
      end
    end
  end

  always_comb begin
    w_sel_x = req_x[3:0];
    w_sel_y = req_y[4:0];
    w_sel_c = req_color[8:0];
    case (w_sel)
      2'd1: begin
        w_sel_x = req_x[7:4];
        w_sel_y = req_y[9:5];
        w_sel_c = req_color[17:9];
      end
      2'd2: begin
        w_sel_x = req_x[11:8];
        w_sel_y = req_y[14:10];
        w_sel_c = req_color[26:18];
      end
      default: ;
    endcase
  end

  assign w_acc      = |req_ready;
  assign w_in_range = ({1'b0, w_sel_x} < COLS_L) && ({1'b0, w_sel_y} < ROWS_L);
  // Out-of-range commands are still consumed (ready was high) but dropped here
  assign w_wr       = w_acc && w_in_range;

  // ---------------------------------------------------------------------------
  // Command FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (w_wr) begin
      r_mem[r_wptr] <= {w_sel_x, w_sel_y, w_sel_c};
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || clear_req) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign {w_head_x, w_head_y, w_head_c} = r_mem[r_rptr];

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  // A box is still in flight if we are waiting and its done has not arrived now
  assign w_outstanding = ((r_state == S_ISSUE_WAIT) || (r_state == S_CLR_WAIT)) && !paint_done;
  assign w_last        = (r_cx == LAST_X) && (r_cy == LAST_Y);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_state <= CLEAR_ON_RESET ? S_CLR_ISSUE : S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pop       = 1'b0;
    w_issue_cmd = 1'b0;
    w_issue_clr = 1'b0;
    w_adv       = 1'b0;
    w_skip_done = 1'b0;
    if (clear_req) begin
      w_state_nxt = w_outstanding ? S_CLR_WAIT : S_CLR_ISSUE;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty && !paint_busy) begin
            w_pop       = 1'b1;
            w_issue_cmd = 1'b1;
            w_state_nxt = S_ISSUE_WAIT;
          end
        end
        S_ISSUE_WAIT: begin
          if (paint_done) begin
            w_state_nxt = S_IDLE;
          end
        end
        S_CLR_ISSUE: begin
          if (!paint_busy) begin
            w_issue_clr = 1'b1;
            w_state_nxt = S_CLR_WAIT;
          end
        end
        S_CLR_WAIT: begin
          if (paint_done) begin
            if (r_skip_adv) begin
              // done of a box started before the sweep restarted: cursor stays
              w_skip_done = 1'b1;
              w_state_nxt = S_CLR_ISSUE;
            end else begin
              w_adv       = 1'b1;
              w_state_nxt = w_last ? S_IDLE : S_CLR_ISSUE;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Painter outputs, sweep cursor, flags
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      r_start     <= 1'b0;
      r_x0        <= '0;
      r_y0        <= '0;
      r_color     <= '0;
      r_cx        <= '0;
      r_cy        <= '0;
      r_clr_color <= clear_color;
      r_clearing  <= CLEAR_ON_RESET;
      r_skip_adv  <= 1'b0;
      r_range_err <= 1'b0;
    end else begin
      r_start <= w_issue_cmd | w_issue_clr;
      if (w_issue_cmd) begin
        r_x0    <= f_x_pix(w_head_x);
        r_y0    <= f_y_pix(w_head_y);
        r_color <= w_head_c;
      end else if (w_issue_clr) begin
        r_x0    <= f_x_pix(r_cx);
        r_y0    <= f_y_pix(r_cy);
        r_color <= r_clr_color;
      end

      if (w_acc && !w_in_range) begin
        r_range_err <= 1'b1;
      end

      if (clear_req) begin
        r_cx        <= '0;
        r_cy        <= '0;
        r_clr_color <= clear_color;
        r_clearing  <= 1'b1;
        r_skip_adv  <= w_outstanding;
      end else begin
        if (w_skip_done) begin
          r_skip_adv <= 1'b0;
        end
        if (w_adv) begin
          if (r_cx == LAST_X) begin
            r_cx <= '0;
            if (r_cy == LAST_Y) begin
              r_cy       <= '0;
              r_clearing <= 1'b0;
            end else begin
              r_cy <= r_cy + 1'b1;
            end
          end else begin
            r_cx <= r_cx + 1'b1;
          end
        end
      end
    end
  end

  assign paint_start = r_start;
  assign paint_x0    = r_x0;
  assign paint_y0    = r_y0;
  assign paint_color = r_color;
  assign clearing    = r_clearing;
  assign range_err   = r_range_err;
  assign sched_busy  = !w_empty || (r_state != S_IDLE);

endmodule

// File: tb/tb_paint_scheduler.sv
module tb_paint_scheduler;

  localparam int COLS = 10;
  localparam int ROWS = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        clear_req;
  logic [8:0]  clear_color;
  logic [2:0]  req_valid;
  logic [2:0]  req_ready;
  logic [11:0] req_x;
  logic [14:0] req_y;
  logic [26:0] req_color;
  logic        paint_start;
  logic [9:0]  paint_x0;
  logic [8:0]  paint_y0;
  logic [8:0]  paint_color;
  logic        paint_busy;
  logic        paint_done;
  logic        clearing;
  logic        sched_busy;
  logic        range_err;

  always #10 clk = ~clk;

  paint_scheduler #(
    .FIFO_DEPTH(4), .CLEAR_ON_RESET(1'b1), .COLS(COLS), .ROWS(ROWS)
  ) dut (
    .CLOCK_50(clk), .reset(reset), .clear_req(clear_req), .clear_color(clear_color),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_color(req_color), .paint_start(paint_start), .paint_x0(paint_x0),
    .paint_y0(paint_y0), .paint_color(paint_color), .paint_busy(paint_busy),
    .paint_done(paint_done), .clearing(clearing), .sched_busy(sched_busy),
    .range_err(range_err)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [8:0] c;
  } exp_t;

  exp_t sb[$];

  int n_cmp = 0;
  int n_err = 0;
  int cnt = 0;
  int dly = 5;
  int n_starts = 0;
  int n_done = 0;
  int ready_viol = 0;
  logic stall = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_cell(input int x, input int y, input logic [8:0] c);
    exp_t e;
    e.x = 10'(x * 64);
    e.y = 9'(y * 24);
    e.c = c;
    sb.push_back(e);
  endtask

  task automatic push_sweep(input logic [8:0] c);
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++)
        push_cell(x, y, c);
  endtask

  task automatic wait_clear(input int budget);
    int i;
    i = 0;
    while (clearing && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("clear_timeout", clearing, 0);
  endtask

  task automatic wait_idle(input int base, input int n, input int budget);
    int i;
    i = 0;
    while (((n_starts - base) < n || sched_busy) && i < budget) begin
      @(negedge clk);
      i++;
    end
    chk("idle_timeout", sched_busy, 0);
  endtask

  // Painter model: done 'dly' cycles after each start; checks every start
  initial begin : painter
    exp_t e;
    paint_busy = 1'b0;
    paint_done = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        cnt        = 0;
        paint_done = 1'b0;
        paint_busy = 1'b0;
      end else begin
        paint_done = 1'b0;
        if (clearing && req_ready != 3'b000) ready_viol++;
        if (paint_start) begin
          chk("start_overlap", cnt, 0);
          if (sb.size() == 0) begin
            chk("unexpected_start", sb.size(), 1);
          end else begin
            e = sb.pop_front();
            chk("start_x0", paint_x0, e.x);
            chk("start_y0", paint_y0, e.y);
            chk("start_color", paint_color, e.c);
          end
          cnt = dly;
          n_starts++;
        end else if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            paint_done = 1'b1;
            n_done++;
          end
        end
        paint_busy = (cnt > 0) || stall;
      end
    end
  end

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  initial begin : main
    int base_s, base_d, k, other, i;
    reset       = 1'b1;
    clear_req   = 1'b0;
    clear_color = 9'h0A5;
    req_valid   = 3'b000;
    req_x       = '0;
    req_y       = '0;
    req_color   = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_start", paint_start, 0);
    chk("rst_x0", paint_x0, 0);
    chk("rst_y0", paint_y0, 0);
    chk("rst_color", paint_color, 0);
    chk("rst_range_err", range_err, 0);
    chk("rst_clearing", clearing, 1);
    chk("rst_ready", req_ready, 0);

    // 1: power-up sweep, requesters held valid throughout
    push_sweep(9'h0A5);
    base_s    = n_starts;
    base_d    = n_done;
    req_valid = 3'b111;
    req_x     = {4'd1, 4'd2, 4'd3};
    req_y     = {5'd1, 5'd2, 5'd3};
    req_color = {9'h001, 9'h002, 9'h003};
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("t1_clearing_first", clearing, 1);
    chk("t1_busy_first", sched_busy, 1);
    wait_clear(3000);
    req_valid = 3'b000;
    chk("t1_starts", n_starts - base_s, 200);
    chk("t1_done_at_fall", n_done - base_d, 200);
    chk("t1_sb_empty", sb.size(), 0);
    chk("t1_ready_in_clear", ready_viol, 0);

    // 2: single command from requester 1, latency
    repeat (2) @(negedge clk);
    base_s = n_starts;
    base_d = n_done;
    push_cell(3, 5, 9'h1C7);
    req_valid        = 3'b010;
    req_x[7:4]       = 4'd3;
    req_y[9:5]       = 5'd5;
    req_color[17:9]  = 9'h1C7;
    #1;
    chk("t2_ready", req_ready, 3'b010);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    @(negedge clk);
    chk("t2_start_early", paint_start, 0);
    @(negedge clk);
    chk("t2_start_latency", paint_start, 1);
    chk("t2_busy", sched_busy, 1);
    wait_idle(base_s, 1, 100);
    chk("t2_done_before_idle", n_done - base_d, 1);
    chk("t2_starts", n_starts - base_s, 1);

    // 3: painter stalled, all requesters valid -> requester 0 fills the FIFO
    stall = 1'b1;
    @(negedge clk);
    @(negedge clk);
    base_s = n_starts;
    k      = 0;
    other  = 0;
    req_valid         = 3'b111;
    req_x[11:4]       = {4'd9, 4'd8};
    req_y[14:5]       = {5'd19, 5'd18};
    req_color[26:9]   = {9'h0F0, 9'h00F};
    repeat (10) begin
      req_x[3:0]     = 4'(k);
      req_y[4:0]     = 5'(k + 2);
      req_color[8:0] = 9'(9'h100 + k);
      #1;
      if (req_ready[0]) begin
        push_cell(k, k + 2, 9'(9'h100 + k));
        k++;
      end
      if (req_ready[2:1] != 2'b00) other++;
      @(negedge clk);
    end
    #1;
    chk("t3_ready_full", req_ready, 0);
    chk("t3_accepted", k, 4);
    chk("t3_other_granted", other, 0);
    chk("t3_no_start_stalled", n_starts - base_s, 0);
    req_valid = 3'b000;
    stall     = 1'b0;
    wait_idle(base_s, 4, 200);
    chk("t3_starts", n_starts - base_s, 4);
    chk("t3_sb_empty", sb.size(), 0);

    // 4: out-of-range commands are consumed and flagged; corner cell works
    @(negedge clk);
    base_s = n_starts;
    chk("t4_err_before", range_err, 0);
    req_valid          = 3'b100;
    req_x[11:8]        = 4'd10;
    req_y[14:10]       = 5'd4;
    req_color[26:18]   = 9'h003;
    #1;
    chk("t4_ready", req_ready, 3'b100);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    chk("t4_err_set", range_err, 1);
    @(negedge clk);
    req_valid      = 3'b001;
    req_x[3:0]     = 4'd2;
    req_y[4:0]     = 5'd20;
    #1;
    chk("t4_ready_y", req_ready, 3'b001);
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    repeat (6) @(negedge clk);
    chk("t4_no_start", n_starts - base_s, 0);
    chk("t4_err_sticky", range_err, 1);
    chk("t4_not_busy", sched_busy, 0);
    push_cell(9, 19, 9'h1FF);
    req_valid      = 3'b001;
    req_x[3:0]     = 4'd9;
    req_y[4:0]     = 5'd19;
    req_color[8:0] = 9'h1FF;
    @(posedge clk);
    #1;
    req_valid = 3'b000;
    wait_idle(base_s, 1, 100);
    chk("t4_corner_start", n_starts - base_s, 1);
    chk("t4_err_still", range_err, 1);

    // 5: clear_req with 3 queued and one box outstanding
    @(negedge clk);
    base_s    = n_starts;
    dly       = 40;
    req_valid = 3'b001;
    push_cell(1, 1, 9'h010);
    for (int j = 0; j < 4; j++) begin
      req_x[3:0]     = 4'(j + 1);
      req_y[4:0]     = 5'(j + 1);
      req_color[8:0] = 9'(9'h010 + j);
      #1;
      chk("t5_ready", req_ready[0], 1);
      @(negedge clk);
    end
    clear_req   = 1'b1;
    clear_color = 9'h155;
    #1;
    chk("t5_ready_on_clear", req_ready, 0);
    chk("t5_outstanding", paint_busy, 1);
    @(posedge clk);
    #1;
    clear_req   = 1'b0;
    req_valid   = 3'b000;
    clear_color = 9'h0FF;
    dly         = 5;
    push_sweep(9'h155);
    chk("t5_clearing", clearing, 1);
    wait_clear(4000);
    chk("t5_starts", n_starts - base_s, 201);
    chk("t5_sb_empty", sb.size(), 0);

    // 6: reset in the middle of a sweep (cell 57 outstanding)
    @(negedge clk);
    base_s    = n_starts;
    clear_req = 1'b1;
    push_sweep(9'h0FF);
    @(posedge clk);
    #1;
    clear_req = 1'b0;
    i = 0;
    while ((n_starts - base_s) < 58 && i < 2000) begin
      @(posedge clk);
      i++;
    end
    chk("t6_reach_57", n_starts - base_s, 58);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("t6_rst_start", paint_start, 0);
    chk("t6_rst_x0", paint_x0, 0);
    chk("t6_rst_y0", paint_y0, 0);
    chk("t6_rst_color", paint_color, 0);
    chk("t6_rst_range_err", range_err, 0);
    chk("t6_rst_clearing", clearing, 1);
    chk("t6_rst_ready", req_ready, 0);
    sb.delete();
    push_sweep(9'h0FF);
    base_s = n_starts;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    wait_clear(3000);
    chk("t6_starts", n_starts - base_s, 200);
    chk("t6_sb_empty", sb.size(), 0);
    chk("ready_in_clear_total", ready_viol, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
